// File: rtl/multicycle_control_fsm.sv
// ============================================================================
// multicycle_control_fsm
//
// Purpose:
//   Main control unit of a multicycle MIPS-style datapath. A single 4-bit
//   Moore state register steps through fetch, decode and the per-instruction
//   execution phases. Every control output is decoded combinationally from
//   the state alone. The one exception is the PC/IR write enable in FETCH,
//   which is also qualified by mem_ready.
//
// Configuration macro:
//   CTRL_ILLEGAL_TRAP_EN
//     - defined:   an unknown opcode in DECODE enters TRAP. TRAP drives
//                  illegal=1 with all other controls 0 and holds until reset.
//     - undefined: an unknown opcode returns to FETCH. TRAP cannot be
//                  reached and illegal is always 0.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  asynchronous, active-low reset
//   opcode     in   6  instruction opcode (used in DECODE and MEMADR)
//   mem_ready  in   1  memory access completes this cycle
//   state      out  4  current state encoding
//   pcwrite    out  1  PC write enable
//   branch     out  1  conditional PC write (qualified by zero externally)
//   iord       out  1  memory address select (0=PC, 1=ALUOut)
//   memwrite   out  1  memory write strobe
//   irwrite    out  1  instruction register write enable
//   regdst     out  1  write register select (1=rd)
//   memtoreg   out  1  writeback source select (1=MDR)
//   regwrite   out  1  register file write enable
//   alusrca    out  1  ALU A select (1=register A)
//   alusrcb    out  2  ALU B select (00=B, 01=4, 10=SignImm, 11=SignImm<<2)
//   aluop      out  2  00=add, 01=sub, 10=funct decode
//   pcsrc      out  2  PC source (00=ALUResult, 01=ALUOut, 10=jump target)
//   illegal    out  1  illegal opcode trap indicator
// ============================================================================
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic [3:0] state,
    output logic       pcwrite,
    output logic       branch,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_TRAP    = 4'd12
    } state_e;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Where DECODE sends an opcode it does not recognise.
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam state_e ILLEGAL_DEST = S_TRAP;
`else
    localparam state_e ILLEGAL_DEST = S_FETCH;
`endif

    state_e state_q;
    state_e state_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = ILLEGAL_DEST;
                endcase
            end
            S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE: state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP:    state_d = S_TRAP;
`endif
            // Unused codes, including TRAP when trapping is disabled,
            // recover to FETCH.
            default:   state_d = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore). All outputs default to 0.
    // ------------------------------------------------------------------
    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        pcsrc    = 2'b00;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                // The PC increment and the IR load happen only on the cycle
                // memory returns the instruction. Both are held off while
                // reset is asserted, because the state is already FETCH then.
                alusrcb = 2'b01;
                pcwrite = mem_ready & rst;
                irwrite = mem_ready & rst;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP: begin
                illegal = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ============================================================================
// tb_multicycle_control_fsm
//
// Self-checking bench for multicycle_control_fsm. The reference model
// describes each instruction as an ordered list of phases. The wait
// phases (FETCH, MEMRD, MEMWR) repeat until mem_ready is high. Each phase
// has an expected control word. Directed scenarios run first, then a long
// randomized run with occasional asynchronous reset pulses.
// ============================================================================
module tb_multicycle_control_fsm;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic [3:0] state;
    logic       pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg;
    logic       regwrite, alusrca, illegal;
    logic [1:0] alusrcb, aluop, pcsrc;

    // Control word, packed for comparison:
    // {pcwrite,branch,iord,memwrite,irwrite,regdst,memtoreg,regwrite,
    //  alusrca,alusrcb[1:0],aluop[1:0],pcsrc[1:0],illegal}
    logic [15:0] ctrl;
    assign ctrl = {pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg,
                   regwrite, alusrca, alusrcb, aluop, pcsrc, illegal};

    multicycle_control_fsm dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .state     (state),
        .pcwrite   (pcwrite),
        .branch    (branch),
        .iord      (iord),
        .memwrite  (memwrite),
        .irwrite   (irwrite),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .regwrite  (regwrite),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .aluop     (aluop),
        .pcsrc     (pcsrc),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_state = 0;
    int plan[$];
    int txn_count = 0;
    int txn_cycles = 0;
    logic [5:0]  txn_op = 6'd0;
    logic [15:0] last_ctrl = 16'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected control word for a phase, written field by field from the
    // per-phase control table.
    function automatic logic [15:0] exp_ctrl(input int st, input bit mr);
        bit pw = 0, br = 0, io = 0, mw = 0, ir = 0, rd = 0, mt = 0, rw = 0, sa = 0, il = 0;
        bit [1:0] sb = 0, ao = 0, ps = 0;
        case (st)
            0:  begin sb = 2'b01; pw = mr; ir = mr; end
            1:  begin sb = 2'b11; end
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin io = 1; end
            4:  begin mt = 1; rw = 1; end
            5:  begin io = 1; mw = 1; end
            6:  begin sa = 1; ao = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; end
            9:  begin sa = 1; sb = 2'b10; end
            10: begin rw = 1; end
            11: begin ps = 2'b10; pw = 1; end
            12: begin il = 1; end
            default: begin end
        endcase
        return {pw, br, io, mw, ir, rd, mt, rw, sa, sb, ao, ps, il};
    endfunction

    // Phases an instruction visits after FETCH.
    task automatic set_plan(input logic [5:0] op);
        plan.delete();
        case (op)
            OP_LW:    plan = '{1, 2, 3, 4};
            OP_SW:    plan = '{1, 2, 5};
            OP_RTYPE: plan = '{1, 6, 7};
            OP_BEQ:   plan = '{1, 8};
            OP_ADDI:  plan = '{1, 9, 10};
            OP_J:     plan = '{1, 11};
`ifdef CTRL_ILLEGAL_TRAP_EN
            default:  plan = '{1, 12};
`else
            default:  plan = '{1};
`endif
        endcase
    endtask

    // Advance the reference by one clock edge.
    task automatic model_step(input logic [5:0] op, input bit mr);
        if (exp_state != 0) txn_cycles++;
        if (exp_state == 0) begin
            if (mr) begin
                set_plan(op);
                txn_op = op;
                txn_cycles = 1;
                exp_state = plan.pop_front();
            end
        end else if ((exp_state == 3 || exp_state == 5) && !mr) begin
            // Waiting on memory.
        end else if (exp_state == 12) begin
            // Trapped until reset.
        end else if (plan.size() == 0) begin
            exp_state = 0;
            txn_count++;
            $display("txn %0d: op=%b done in %0d cycles after fetch", txn_count, txn_op, txn_cycles);
        end else begin
            exp_state = plan.pop_front();
        end
    endtask

    // One clock cycle. The task is entered 1 time unit after a rising edge.
    // The outputs are checked on the falling edge.
    task automatic cycle(input logic [5:0] op, input bit mr, input string tag);
        opcode = op;
        mem_ready = mr;
        @(negedge clk);
        last_ctrl = ctrl;
        check({tag, "_state"}, 32'(state), 32'(exp_state));
        check({tag, "_ctrl"}, 32'(ctrl), 32'(exp_ctrl(exp_state, mr)));
        @(posedge clk);
        #1;
        model_step(op, mr);
    endtask

    // Run one instruction with mem_ready held high and count the cycles
    // until the DUT is back in FETCH.
    task automatic run_instr(input logic [5:0] op, input int exp_lat, input string tag);
        int n = 0;
        do begin
            cycle(op, 1'b1, tag);
            n++;
        end while (state != 4'd0 && n < 20);
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    endtask

    // Pulse reset between clock edges. The state must collapse to FETCH at
    // once, and the outputs must be the gated FETCH decode.
    task automatic reset_pulse(input string tag);
        rst = 1'b0;
        #1;
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_ctrl"}, 32'(ctrl), 32'h0020);
        #1;
        rst = 1'b1;
        exp_state = 0;
        plan.delete();
    endtask

    function automatic logic [5:0] pick_op();
        int unsigned r = $urandom_range(0, 7);
        case (r)
            0: return OP_LW;
            1: return OP_SW;
            2: return OP_RTYPE;
            3: return OP_BEQ;
            4: return OP_ADDI;
            5: return OP_J;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int mw_cnt;
        logic [5:0] cur_op;

        // Power-up reset, applied asynchronously before any clock edge.
        #1 rst = 1'b0;
        #2;
        check("reset_state", 32'(state), 32'd0);
        check("reset_ctrl", 32'(ctrl), 32'h0020);
        mem_ready = 1'b1;
        #1;
        check("reset_ctrl_mr1", 32'(ctrl), 32'h0020);
        check("reset_illegal", 32'(illegal), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_state = 0;

        // LW, SW, RTYPE, ADDI, BEQ and J with memory always ready.
        run_instr(OP_LW, 5, "lw");
        run_instr(OP_SW, 4, "sw");
        run_instr(OP_RTYPE, 4, "rtype");
        run_instr(OP_ADDI, 4, "addi");
        run_instr(OP_BEQ, 3, "beq");
        run_instr(OP_J, 3, "j");

        // SW with memory stalled for 3 cycles in MEMWR.
        cycle(OP_SW, 1'b1, "swst");
        cycle(OP_SW, 1'b1, "swst");
        cycle(OP_SW, 1'b1, "swst");
        mw_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(OP_SW, i == 3, "swst_hold");
            mw_cnt += int'(last_ctrl[12]);
        end
        check("swst_memwrite_cycles", 32'(mw_cnt), 32'd4);
        check("swst_return", 32'(state), 32'd0);
        $display("txn directed: SW with 3 stall cycles");

        // FETCH stalled for 2 cycles.
        cycle(OP_RTYPE, 1'b0, "fstall");
        check("fstall_pw_ir_low", 32'({last_ctrl[15], last_ctrl[11]}), 32'd0);
        cycle(OP_RTYPE, 1'b0, "fstall");
        cycle(OP_RTYPE, 1'b1, "fstall");
        check("fstall_pw_ir_high", 32'({last_ctrl[15], last_ctrl[11]}), 32'd3);
        for (int i = 0; i < 3; i++) cycle(OP_RTYPE, 1'b1, "fstall");
        check("fstall_return", 32'(state), 32'd0);

        // Illegal opcode.
        cycle(OP_BAD, 1'b1, "illeg");
        cycle(OP_BAD, 1'b1, "illeg");
`ifdef CTRL_ILLEGAL_TRAP_EN
        check("illeg_trap_state", 32'(state), 32'd12);
        for (int i = 0; i < 3; i++) cycle(OP_BAD, i[0], "illeg_hold");
        check("illeg_flag", 32'(illegal), 32'd1);
        reset_pulse("illeg_rst");
        check("illeg_flag_cleared", 32'(illegal), 32'd0);
`else
        check("illeg_state", 32'(state), 32'd0);
        check("illeg_flag", 32'(illegal), 32'd0);
`endif
        $display("txn directed: illegal opcode 111111");

        // Asynchronous reset while LW waits in MEMRD.
        cycle(OP_LW, 1'b1, "rstrd");
        cycle(OP_LW, 1'b1, "rstrd");
        cycle(OP_LW, 1'b1, "rstrd");
        check("rstrd_in_memrd", 32'(state), 32'd3);
        mem_ready = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("rstrd_state_async", 32'(state), 32'd0);
        check("rstrd_regwrite", 32'(regwrite), 32'd0);
        @(posedge clk);
        #1;
        check("rstrd_state_held", 32'(state), 32'd0);
        check("rstrd_strobes", 32'({regwrite, memwrite, pcwrite, irwrite}), 32'd0);
        rst = 1'b1;
        exp_state = 0;
        plan.delete();
        $display("txn directed: reset during MEMRD");

        // Randomized run.
        cur_op = OP_LW;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 59) == 0) reset_pulse("rnd_rst");
            if (exp_state == 0) cur_op = pick_op();
            cycle(cur_op, $urandom_range(0, 3) != 0, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
